// File: rtl/mips_avalon_arbiter.sv
// Arbitrates N cached read clients and a posted write buffer onto one Avalon-MM master port.
// Latency: read strobe one cycle after the request at zero wait states; one IDLE cycle between transactions.
// Backpressure: mem_waitrequest stalls the active transaction; wr_ready drops while the write buffer is full.
module mips_avalon_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int WB_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_byteenable,
  output logic                     wr_ready,
  output logic                     wb_empty,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic [DATA_W/8-1:0]      mem_byteenable,
  input  logic                     mem_waitrequest,
  input  logic [DATA_W-1:0]        mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(WB_DEPTH);
  localparam int CW   = PW + 1;
  localparam int GW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, rr_next, pick;
  logic              pick_vld;
  logic [NUM_RD-1:0] eligible;

  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [BE_W-1:0]   wb_be   [WB_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, idx;
  logic [CW-1:0]     count;
  logic              full, empty, push, pop, hit;
  int                cand;

  assign full     = (count == CW'(WB_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_req && !full;
  assign pop      = (state == WRITE) && !mem_waitrequest;
  assign wr_ready = !full;
  assign wb_empty = empty;
  assign rd_data  = mem_readdata;

  // Write buffer payload; entries past the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= wr_addr;
      wb_data[wr_ptr] <= wr_data;
      wb_be[wr_ptr]   <= wr_byteenable;
    end
  end

  // Write buffer pointers and occupancy; a push while full was already masked out of push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A read is blocked by any buffered write to the same word, including one being pushed this cycle,
  // so that a write and a read to the same word issued together still complete write-first.
  always_comb begin
    eligible = '0;
    hit      = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hit = push && (wr_addr[ADDR_W-1:2] == rd_addr[i*ADDR_W+2 +: ADDR_W-2]);
      for (int k = 0; k < WB_DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if ((CW'(k) < count) && (wb_addr[idx][ADDR_W-1:2] == rd_addr[i*ADDR_W+2 +: ADDR_W-2]))
          hit = 1'b1;
      end
      eligible[i] = rd_req[i] && !hit;
    end
  end

  // Round-robin pick: first eligible client at or after rr_next.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = 0;
    for (int k = 0; k < NUM_RD; k++) begin
      cand = (int'(rr_next) + k) % NUM_RD;
      if (!pick_vld && eligible[cand]) begin
        pick_vld = 1'b1;
        pick     = GW'(cand);
      end
    end
  end

  // State, grant and round-robin pointer registers; grant is frozen for the whole READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_next <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == READ) begin
        grant   <= pick;
        rr_next <= (pick == GW'(NUM_RD - 1)) ? '0 : pick + 1'b1;
      end
    end
  end

  // Next state: a full buffer drains first, then reads win over draining writes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (full)          state_nxt = WRITE;
        else if (pick_vld) state_nxt = READ;
        else if (!empty)   state_nxt = WRITE;
        else               state_nxt = IDLE;
      end
      READ:    if (!mem_waitrequest) state_nxt = IDLE;
      WRITE:   if (!mem_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs decoded from state; they only depend on registered grant and head, so they hold under waitrequest.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    rd_valid       = '0;
    case (state)
      READ: begin
        mem_read        = 1'b1;
        mem_address     = rd_addr[int'(grant)*ADDR_W +: ADDR_W];
        mem_byteenable  = '1;
        rd_valid[grant] = !mem_waitrequest;
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = wb_addr[rd_ptr];
        mem_writedata  = wb_data[rd_ptr];
        mem_byteenable = wb_be[rd_ptr];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mips_avalon_arbiter.md
MIPS_AVALON_ARBITER -- requirements
Module: mips_avalon_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read clients (instr/data caches and others).
REQ-004 SHALL have parameter WB_DEPTH, default 4, write-buffer entries (power of 2, >=2).
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-high:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
REQ-006 SHALL have client ports:
  rd_req  in  NUM_RD  per-client read request
  rd_addr  in  NUM_RD*ADDR_W  client i address at slice i
  rd_data  out  DATA_W  read data, valid while rd_valid set
  rd_valid  out  NUM_RD  one-hot completion strobe
  wr_req  in  1  push write into buffer
  wr_addr  in  ADDR_W  write address
  wr_data  in  DATA_W  write data
  wr_byteenable  in  DATA_W/8  write byte lanes
  wr_ready  out  1  buffer not full
  wb_empty  out  1  buffer empty
REQ-007 SHALL have Avalon ports:
  mem_address  out  ADDR_W
  mem_read  out  1
  mem_write  out  1
  mem_writedata  out  DATA_W
  mem_byteenable  out  DATA_W/8
  mem_waitrequest  in  1
  mem_readdata  in  DATA_W

Function
REQ-008 SHALL implement the write buffer as a FIFO of {addr, data, byteenable}; push when wr_req && wr_ready.
REQ-009 SHALL drive wr_ready = !full, computed from the occupancy at cycle start. A push while full is dropped, even if a pop occurs in the same cycle.
REQ-010 SHALL support simultaneous push and pop when not full; occupancy is then unchanged. Pointers SHALL wrap modulo WB_DEPTH.
REQ-011 SHALL mark read client i eligible when rd_req[i] is set and rd_addr[i] word address (bits ADDR_W-1:2) matches no valid buffer entry.
REQ-012 SHALL implement states IDLE, READ and WRITE in a registered state machine.
REQ-013 IDLE: if the buffer is full and not empty -> WRITE. Else if any client is eligible -> READ, granting round-robin starting after the last granted client. Else if !wb_empty -> WRITE. Else stay.
REQ-014 READ: mem_read=1, mem_address=rd_addr[grant], mem_byteenable all ones. When !mem_waitrequest: rd_valid[grant]=1 for that cycle only, rd_data=mem_readdata, then -> IDLE.
REQ-015 WRITE: mem_write=1 with mem_address, mem_writedata and mem_byteenable taken from the FIFO head. When !mem_waitrequest: pop, then -> IDLE.
REQ-016 A blocked read (address match) SHALL be serviced only after the matching entries have drained; writes drain in FIFO order.
REQ-017 In IDLE, mem_read=0, mem_write=0 and rd_valid=0. mem_read and mem_write SHALL never be set together.
REQ-018 Bus signals SHALL be held stable while mem_waitrequest=1. Grant and head entry SHALL not change mid-transaction.
REQ-019 Clients SHALL hold rd_req and rd_addr until rd_valid. Dropping rd_req mid-transaction is a protocol violation; the arbiter still completes the transaction.
REQ-020 Latency: minimum 2 cycles from rd_req to rd_valid with zero wait states (IDLE then READ). The turnaround between transactions is one IDLE cycle.
REQ-021 Round-robin SHALL guarantee each continuously requesting eligible client a grant within NUM_RD read transactions.

Reset
REQ-022 rst SHALL asynchronously force: state=IDLE, FIFO pointers and count=0, round-robin pointer to client 0 (next grant client 0), mem_read=0, mem_write=0, rd_valid=0.
REQ-023 Under reset, outputs SHALL read wr_ready=1 and wb_empty=1. Buffered writes are discarded.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately; no rd_valid and no pop occurs.

Verification
REQ-025 Single read: rd_req=01, rd_addr[0]=0x100, waitrequest 0, readdata 0xDEADBEEF -> rd_valid=01 in cycle 2, rd_data=0xDEADBEEF.
REQ-026 Round-robin: rd_req=11 held -> grants alternate 0,1,0,1; each strobe is one cycle.
REQ-027 Coherency: push write 0x200=0x5; same cycle rd_req[1] to 0x200 -> WRITE completes before READ; read returns the memory value after the write.
REQ-028 Full buffer: 4 pushes with waitrequest=1 -> wr_ready=0, 5th push dropped; writes drain in order even with reads pending.
REQ-029 Waitrequest: 3 wait cycles on a write -> mem_address, mem_writedata and mem_byteenable stable for all 4 cycles; single pop.
REQ-030 Reset mid-READ -> mem_read=0 immediately, no rd_valid, wb_empty=1 after release.
